// File: rtl/hazard_if.sv
// hazard_if: bundle between the pipeline controller/datapath and the hazard unit
//   master : controller/datapath side, drives stage strobes and register addresses,
//            receives forwarding selects, stall/flush strobes and counters
//   slave  : hazard unit side
//   CNT_W must match the CNT_W of the hazard_unit it is connected to
interface hazard_if #(parameter int CNT_W = 16);
    logic [3:0]       RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic             RegWriteM, RegWriteW, MemToRegE;
    logic             PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, LongE;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy;
    logic [CNT_W-1:0] StallCount, FlushCount;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        output RegWriteM, RegWriteW, MemToRegE,
        output PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, LongE,
        input  ForwardAE, ForwardBE,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy,
        input  StallCount, FlushCount
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        input  RegWriteM, RegWriteW, MemToRegE,
        input  PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, LongE,
        output ForwardAE, ForwardBE,
        output StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy,
        output StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding, stall/flush control, long-op occupancy FSM and
// saturating stall/flush performance counters for a 5-stage pipeline.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   hz    : hazard_if slave (stage strobes/addresses in, forward/stall/flush/counters out)
module hazard_unit #(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input logic     clk,
    input logic     reset,
    hazard_if.slave hz
);
    localparam int CW = $clog2(MUL_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             ld_stall, mul_stall, pc_wr_pend, stall_d, flush_e;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    // r15 is the PC, never forwarded; M result is younger so it wins over W
    assign hz.ForwardAE = (hz.RegWriteM && hz.RA1E == hz.WA3M && hz.RA1E != 4'd15) ? 2'b10 :
                          (hz.RegWriteW && hz.RA1E == hz.WA3W && hz.RA1E != 4'd15) ? 2'b01 : 2'b00;
    assign hz.ForwardBE = (hz.RegWriteM && hz.RA2E == hz.WA3M && hz.RA2E != 4'd15) ? 2'b10 :
                          (hz.RegWriteW && hz.RA2E == hz.WA3W && hz.RA2E != 4'd15) ? 2'b01 : 2'b00;

    // every strobe is gated by reset so the pipeline is quiet while reset is held
    assign ld_stall   = reset && hz.MemToRegE && (hz.RA1D == hz.WA3E || hz.RA2D == hz.WA3E);
    assign mul_stall  = reset && ((state == IDLE && hz.LongE && MUL_CYCLES >= 2) ||
                                  (state == BUSY && cnt != '0));
    assign pc_wr_pend = reset && (hz.PCSrcD || hz.PCSrcE || hz.PCSrcM);
    assign stall_d    = ld_stall || mul_stall;
    assign flush_e    = (ld_stall || (reset && hz.BranchTakenE)) && !mul_stall;

    assign hz.StallF     = stall_d || pc_wr_pend;
    assign hz.StallD     = stall_d;
    assign hz.StallE     = mul_stall;
    assign hz.FlushM     = mul_stall;
    assign hz.FlushE     = flush_e;
    assign hz.FlushD     = reset && (pc_wr_pend || hz.PCSrcW || hz.BranchTakenE) && !stall_d;
    assign hz.MulBusy    = state == BUSY;
    assign hz.StallCount = stall_cnt;
    assign hz.FlushCount = flush_cnt;

    // IDLE counts as the first E cycle, so BUSY loads MUL_CYCLES-2 and releases at cnt==0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (state == IDLE) begin
            if (hz.LongE && MUL_CYCLES >= 2) begin
                state <= BUSY;
                cnt   <= CW'(MUL_CYCLES - 2);
            end
        end else if (cnt == '0) begin
            state <= IDLE;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_d && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
            if (flush_e && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule
